// File: rtl/event_counter_pkg.sv
// Shared constants and the 7-segment decoder for the multi-channel event counter.
package event_counter_pkg;

    // Counter overflow behaviour selectors
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Hex nibble to active-low 7-segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/event_channel.sv
// One event channel: input synchroniser, rising-edge detect, counter and sticky overflow.
module event_channel
    import event_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SATURATE    = MODE_WRAP,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_in,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   edge_det;

    // Metastability synchroniser shift chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], event_in};
        end
    end

    // Edge history; updates every cycle regardless of clear or enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync[SYNC_STAGES-1] & ~prev;

    // Counter and sticky overflow: clear beats enable beats edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (enable && edge_det) begin
            if (count == COUNT_MAX) begin
                ovf <= 1'b1;
                if (SATURATE != MODE_SAT) begin
                    count <= '0;
                end
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/event_counter_multi.sv
// Multi-channel event counter with selectable readout, threshold flags and 7-segment digit.
module event_counter_multi
    import event_counter_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] EVENT_IN,
    input  logic [CHANNELS-1:0] CLEAR,
    input  logic                ENABLE,
    input  logic [WIDTH-1:0]    THRESHOLD,
    input  logic [SEL_W-1:0]    SEL,
    output logic [WIDTH-1:0]    COUNT,
    output logic [CHANNELS-1:0] HIT,
    output logic [CHANNELS-1:0] OVF,
    output logic [6:0]          HEX0
);

    logic [WIDTH-1:0] counts [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        event_channel #(
            .WIDTH       (WIDTH),
            .SATURATE    (SATURATE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (CLOCK_50),
            .rst      (RESET),
            .event_in (EVENT_IN[i]),
            .clear    (CLEAR[i]),
            .enable   (ENABLE),
            .count    (counts[i]),
            .ovf      (OVF[i])
        );
    end

    // Readout mux; an out-of-range select reads as zero
    always_comb begin
        COUNT = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (SEL == SEL_W'(i)) begin
                COUNT = counts[i];
            end
        end
    end

    // Threshold compare against the live threshold input
    always_comb begin
        HIT = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            HIT[i] = (counts[i] >= THRESHOLD);
        end
    end

    // Low nibble of the selected count shown on the board digit
    always_comb begin
        HEX0 = hex_to_seg(COUNT[3:0]);
    end

endmodule

// File: tb/tb_event_counter_multi.sv
// Scoreboard bench: wrap and saturate instances share stimulus; a negedge monitor checks queued expectations.
module tb_event_counter_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ev;
    logic [3:0] clr;
    logic       en;
    logic [7:0] th;
    logic [1:0] sel;

    logic [7:0] cnt_w, cnt_s;
    logic [3:0] hit_w, hit_s, ovf_w, ovf_s;
    logic [6:0] hex_w, hex_s;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        int         inst;
        logic [7:0] count;
        logic [3:0] hit;
        logic [3:0] ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    event_counter_multi #(.CHANNELS(4), .WIDTH(8), .SATURATE(0), .SYNC_STAGES(2)) dut_wrap (
        .CLOCK_50 (clk), .RESET (rst), .EVENT_IN (ev), .CLEAR (clr), .ENABLE (en),
        .THRESHOLD (th), .SEL (sel), .COUNT (cnt_w), .HIT (hit_w), .OVF (ovf_w), .HEX0 (hex_w)
    );

    event_counter_multi #(.CHANNELS(4), .WIDTH(8), .SATURATE(1), .SYNC_STAGES(2)) dut_sat (
        .CLOCK_50 (clk), .RESET (rst), .EVENT_IN (ev), .CLEAR (clr), .ENABLE (en),
        .THRESHOLD (th), .SEL (sel), .COUNT (cnt_s), .HIT (hit_s), .OVF (ovf_s), .HEX0 (hex_s)
    );

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Monitor: pops every pending expectation and compares against the addressed instance
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                cmp({e.name, ".wrap.count"}, 32'(cnt_w), 32'(e.count));
                cmp({e.name, ".wrap.hit"},   32'(hit_w), 32'(e.hit));
                cmp({e.name, ".wrap.ovf"},   32'(ovf_w), 32'(e.ovf));
                cmp({e.name, ".wrap.hex"},   32'(hex_w), 32'(seg_tab[e.count[3:0]]));
            end else begin
                cmp({e.name, ".sat.count"},  32'(cnt_s), 32'(e.count));
                cmp({e.name, ".sat.hit"},    32'(hit_s), 32'(e.hit));
                cmp({e.name, ".sat.ovf"},    32'(ovf_s), 32'(e.ovf));
                cmp({e.name, ".sat.hex"},    32'(hex_s), 32'(seg_tab[e.count[3:0]]));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic exp2(input string nm,
                        input logic [7:0] cw, input logic [3:0] hw, input logic [3:0] ow,
                        input logic [7:0] cs, input logic [3:0] hs, input logic [3:0] os);
        exp_t a;
        exp_t b;
        a.name = nm; a.inst = 0; a.count = cw; a.hit = hw; a.ovf = ow;
        b.name = nm; b.inst = 1; b.count = cs; b.hit = hs; b.ovf = os;
        sb.push_back(a);
        sb.push_back(b);
        drain();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] mask, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            ev = ev | mask;
            step(hi);
            ev = ev & ~mask;
            step(lo);
        end
    endtask

    initial begin
        rst = 1'b1; ev = '0; clr = '0; en = 1'b1; th = 8'd0; sel = 2'd0;
        step(2);
        exp2("reset_th0", 8'd0, 4'hF, 4'h0, 8'd0, 4'hF, 4'h0);
        th = 8'd200;
        exp2("reset_th200", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        step(2);

        // Basic count and two-edge latency on channel 0
        ev = 4'b0001;
        step(2);
        exp2("t1_lat_k1", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);
        step(1);
        exp2("t1_lat_k2", 8'd1, 4'h0, 4'h0, 8'd1, 4'h0, 4'h0);
        step(1);
        ev = 4'b0000;
        step(4);
        pulse(4'b0001, 4, 4, 4);
        exp2("t1_five", 8'd5, 4'h0, 4'h0, 8'd5, 4'h0, 4'h0);
        sel = 2'd1;
        exp2("t1_other", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);

        // Wrap versus saturate on channel 1
        pulse(4'b0010, 256, 2, 2);
        exp2("t2_256", 8'd0, 4'h0, 4'b0010, 8'd255, 4'b0010, 4'b0010);
        pulse(4'b0010, 3, 2, 2);
        exp2("t2_259", 8'd3, 4'h0, 4'b0010, 8'd255, 4'b0010, 4'b0010);

        // Clear wins over a coincident edge on channel 2
        sel = 2'd2;
        pulse(4'b0100, 263, 2, 2);
        exp2("t3_pre", 8'd7, 4'h0, 4'b0110, 8'd255, 4'b0110, 4'b0110);
        ev = 4'b0100;
        step(2);
        clr = 4'b0100;
        step(1);
        clr = 4'b0000;
        exp2("t3_clear", 8'd0, 4'h0, 4'b0010, 8'd0, 4'b0010, 4'b0010);
        step(3);
        exp2("t3_hold", 8'd0, 4'h0, 4'b0010, 8'd0, 4'b0010, 4'b0010);
        ev = 4'b0000;
        step(3);

        // Enable gating and threshold on channel 3
        sel = 2'd3;
        th  = 8'd3;
        en  = 1'b0;
        pulse(4'b1000, 2, 4, 4);
        exp2("t4_disabled", 8'd0, 4'b0011, 4'b0010, 8'd0, 4'b0011, 4'b0010);
        en = 1'b1;
        pulse(4'b1000, 3, 4, 4);
        exp2("t4_th3", 8'd3, 4'b1011, 4'b0010, 8'd3, 4'b1011, 4'b0010);
        th = 8'd4;
        exp2("t4_th4", 8'd3, 4'b0001, 4'b0010, 8'd3, 4'b0011, 4'b0010);

        // Simultaneous edges on all channels
        th  = 8'd10;
        clr = 4'hF;
        step(1);
        clr = 4'h0;
        sel = 2'd0;
        exp2("t5_cleared", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);
        pulse(4'hF, 10, 4, 4);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            exp2($sformatf("t5_sel%0d", s), 8'd10, 4'hF, 4'h0, 8'd10, 4'hF, 4'h0);
        end

        // Asynchronous reset mid-count with channel 0 held high
        sel = 2'd0;
        ev  = 4'b0001;
        step(4);
        exp2("t6_pre", 8'd11, 4'hF, 4'h0, 8'd11, 4'hF, 4'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp2("t6_in_reset", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);
        sel = 2'd1;
        exp2("t6_in_reset_ch1", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        step(6);
        sel = 2'd0;
        exp2("t6_ch0_one", 8'd1, 4'h0, 4'h0, 8'd1, 4'h0, 4'h0);
        sel = 2'd1;
        exp2("t6_ch1_zero", 8'd0, 4'h0, 4'h0, 8'd0, 4'h0, 4'h0);
        th = 8'd0;
        exp2("t6_th0", 8'd0, 4'hF, 4'h0, 8'd0, 4'hF, 4'h0);
        th = 8'd1;
        exp2("t6_th1", 8'd0, 4'b0001, 4'h0, 8'd0, 4'b0001, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
